// File: rtl/riscv_pkg.sv
// Shared RV64 decode types: opcode encodings, immediate formats and the
// decoded bundle carried by the decode stage's output and skid registers.
package riscv_pkg;

    // Bundle fields are sized for the widest datapath; narrower builds
    // use the low XLEN bits.
    localparam int XLEN_MAX = 64;

    typedef enum logic [6:0] {
        OPC_NONE      = 7'h00,
        OPC_LOAD      = 7'h03,
        OPC_MISC_MEM  = 7'h0F,
        OPC_OP_IMM    = 7'h13,
        OPC_AUIPC     = 7'h17,
        OPC_OP_IMM_32 = 7'h1B,
        OPC_STORE     = 7'h23,
        OPC_OP        = 7'h33,
        OPC_LUI       = 7'h37,
        OPC_OP_32     = 7'h3B,
        OPC_BRANCH    = 7'h63,
        OPC_JALR      = 7'h67,
        OPC_JAL       = 7'h6F,
        OPC_SYSTEM    = 7'h73
    } opcode_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        opcode_t             opcode;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [2:0]          funct3;
        logic [6:0]          funct7;
        logic [XLEN_MAX-1:0] imm;
        logic                illegal;
    } decoded_t;

    // Immediate format implied by the 7-bit opcode field.
    function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opc);
        imm_fmt_t fmt;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: fmt = IMM_I;
            OPC_STORE:                                     fmt = IMM_S;
            OPC_BRANCH:                                    fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                            fmt = IMM_U;
            OPC_JAL:                                       fmt = IMM_J;
            default:                                       fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator for the RV base instruction formats.
// Every format fits a signed 32-bit value, which is then sign-extended to XLEN.
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  imm_fmt_t        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;
    logic        unused_opcode_bits;

    // The opcode bits are decoded upstream into fmt.
    assign unused_opcode_bits = ^instr[6:0];

    // Assemble the 32-bit signed immediate for the selected format.
    always_comb begin
        imm32 = '0;
        case (fmt)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'b0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered RV64 decode stage with valid/ready handshake and flush.
// REG_READY=0: single output register, in_ready_o combinational from out_ready_i.
// REG_READY=1: output register plus one skid entry, in_ready_o from a flop.
// Optional macro DECODE_ILLEGAL_CHECK_EN enables the illegal-opcode flag.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once out_valid_o is raised, the bundle stays stable until it
// transfers; flush_i (below rst_i) discards everything held and any input
// presented in the same cycle.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int REG_READY = 0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] pc_o,
    output opcode_t         opcode_o,
    output logic [4:0]      rd_addr_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,
    output logic [XLEN-1:0] imm_o,
    output logic            illegal_o
);

    imm_fmt_t        fmt;
    logic [XLEN-1:0] imm_x;
    logic            illegal;
    decoded_t        dec;
    decoded_t        out_q;
    logic            out_valid_q;
    logic            in_ready;
    logic            in_fire;

    assign fmt = imm_fmt_of(instr_i[6:0]);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (instr_i),
        .fmt   (fmt),
        .imm   (imm_x)
    );

`ifdef DECODE_ILLEGAL_CHECK_EN
    // Flag opcodes outside the supported base set, including compressed encodings.
    always_comb begin
        case (instr_i[6:0])
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI,
            OPC_AUIPC, OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32,
            OPC_MISC_MEM, OPC_SYSTEM: illegal = (instr_i[1:0] != 2'b11);
            default:                  illegal = 1'b1;
        endcase
    end
`else
    assign illegal = 1'b0;
`endif

    // Slice the raw instruction into the bundle that gets registered.
    always_comb begin
        dec         = '0;
        dec.pc      = XLEN_MAX'(pc_i);
        dec.opcode  = opcode_t'(instr_i[6:0]);
        dec.rd      = instr_i[11:7];
        dec.rs1     = instr_i[19:15];
        dec.rs2     = instr_i[24:20];
        dec.funct3  = instr_i[14:12];
        dec.funct7  = instr_i[31:25];
        dec.imm     = XLEN_MAX'($signed(imm_x));
        dec.illegal = illegal;
    end

    // Flush drops the input even when the stage could accept it.
    assign in_fire = in_valid_i && in_ready && !flush_i;

    generate
        if (REG_READY != 0) begin : g_skid
            decoded_t skid_q;
            logic     skid_valid_q;
            logic     ready_q;

            // Output register plus skid entry; ready_q tracks "skid will be empty".
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    out_q        <= '0;
                    out_valid_q  <= 1'b0;
                    skid_q       <= '0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end else if (flush_i) begin
                    out_valid_q  <= 1'b0;
                    skid_valid_q <= 1'b0;
                    ready_q      <= 1'b1;
                end else if (!out_valid_q || out_ready_i) begin
                    // Output slot frees this cycle: the older skid entry goes first.
                    if (skid_valid_q) begin
                        out_q        <= skid_q;
                        out_valid_q  <= 1'b1;
                        skid_valid_q <= 1'b0;
                        ready_q      <= 1'b1;
                    end else if (in_fire) begin
                        out_q       <= dec;
                        out_valid_q <= 1'b1;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end else if (in_fire) begin
                    // Output held: park the new bundle and stop accepting.
                    skid_q       <= dec;
                    skid_valid_q <= 1'b1;
                    ready_q      <= 1'b0;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_pass
            // Single output register; reloads whenever an input transfers.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    out_q       <= '0;
                    out_valid_q <= 1'b0;
                end else if (flush_i) begin
                    out_valid_q <= 1'b0;
                end else if (in_fire) begin
                    out_q       <= dec;
                    out_valid_q <= 1'b1;
                end else if (out_valid_q && out_ready_i) begin
                    out_valid_q <= 1'b0;
                end
            end

            assign in_ready = !out_valid_q || out_ready_i;
        end
    endgenerate

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign pc_o        = out_q.pc[XLEN-1:0];
    assign opcode_o    = out_q.opcode;
    assign rd_addr_o   = out_q.rd;
    assign rs1_addr_o  = out_q.rs1;
    assign rs2_addr_o  = out_q.rs2;
    assign funct3_o    = out_q.funct3;
    assign funct7_o    = out_q.funct7;
    assign imm_o       = out_q.imm[XLEN-1:0];
    assign illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: one instance per REG_READY setting sharing stimulus.
module tb_decode_stage;
  import riscv_pkg::*;

  localparam int XLEN = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;

  logic        in_ready0, out_valid0, ill0, in_ready1, out_valid1, ill1;
  logic [63:0] pc_o0, imm0, pc_o1, imm1;
  opcode_t     opc0, opc1;
  logic [4:0]  rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
  logic [2:0]  f3_0, f3_1;
  logic [6:0]  f7_0, f7_1;

  decode_stage #(.XLEN(XLEN), .REG_READY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready0), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .pc_o(pc_o0), .opcode_o(opc0), .rd_addr_o(rd0),
    .rs1_addr_o(rs1_0), .rs2_addr_o(rs2_0), .funct3_o(f3_0), .funct7_o(f7_0),
    .imm_o(imm0), .illegal_o(ill0)
  );

  decode_stage #(.XLEN(XLEN), .REG_READY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready1), .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .pc_o(pc_o1), .opcode_o(opc1), .rd_addr_o(rd1),
    .rs1_addr_o(rs1_1), .rs2_addr_o(rs2_1), .funct3_o(f3_1), .funct7_o(f7_1),
    .imm_o(imm1), .illegal_o(ill1)
  );

  typedef struct packed {
    logic        in_ready;
    logic        out_valid;
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        illegal;
  } obs_t;

  obs_t obs0, obs1;

  always_comb begin
    obs0 = '0;
    obs0.in_ready = in_ready0; obs0.out_valid = out_valid0; obs0.pc = pc_o0;
    obs0.opcode = opc0; obs0.rd = rd0; obs0.rs1 = rs1_0; obs0.rs2 = rs2_0;
    obs0.f3 = f3_0; obs0.f7 = f7_0; obs0.imm = imm0; obs0.illegal = ill0;
    obs1 = '0;
    obs1.in_ready = in_ready1; obs1.out_valid = out_valid1; obs1.pc = pc_o1;
    obs1.opcode = opc1; obs1.rd = rd1; obs1.rs1 = rs1_1; obs1.rs2 = rs2_1;
    obs1.f3 = f3_1; obs1.f7 = f7_1; obs1.imm = imm1; obs1.illegal = ill1;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } item_t;

  item_t       q0[$];
  item_t       q1[$];
  logic [63:0] seen1[$];
  bit          reset_seen = 0;
  int          total = 0;
  int          bad = 0;

  function automatic longint fld(input logic [31:0] w, input int hi, input int lo);
    return longint'((w >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1));
  endfunction

  // Immediate as a signed number built from weighted instruction fields.
  function automatic logic [63:0] ref_imm(input logic [31:0] w);
    longint v;
    v = 0;
    case (int'(w[6:0]))
      'h03, 'h13, 'h1B, 'h67: begin
        v = fld(w, 31, 20);
        if (v >= 2048) v = v - 4096;
      end
      'h23: begin
        v = fld(w, 31, 25) * 32 + fld(w, 11, 7);
        if (v >= 2048) v = v - 4096;
      end
      'h63: begin
        v = fld(w, 31, 31) * 4096 + fld(w, 7, 7) * 2048 + fld(w, 30, 25) * 32 + fld(w, 11, 8) * 2;
        if (v >= 4096) v = v - 8192;
      end
      'h37, 'h17: begin
        v = fld(w, 31, 12) * 4096;
        if (v >= 64'sh8000_0000) v = v - 64'sh1_0000_0000;
      end
      'h6F: begin
        v = fld(w, 31, 31) * (1 << 20) + fld(w, 19, 12) * 4096 + fld(w, 20, 20) * 2048 + fld(w, 30, 21) * 2;
        if (v >= (1 << 20)) v = v - (1 << 21);
      end
      default: v = 0;
    endcase
    return v;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] w);
`ifdef DECODE_ILLEGAL_CHECK_EN
    return (w[1:0] != 2'b11) ||
           !(int'(w[6:0]) inside {'h03, 'h23, 'h63, 'h6F, 'h67, 'h37, 'h17, 'h13, 'h1B,
                                  'h33, 'h3B, 'h0F, 'h73});
`else
    return (w == 32'hFFFF_FFFF) && (w != 32'hFFFF_FFFF);
`endif
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_obs(input string tag, input obs_t o, input bit ev, input bit er, input item_t it);
    cmp({tag, " in_ready"}, 64'(o.in_ready), 64'(er));
    cmp({tag, " out_valid"}, 64'(o.out_valid), 64'(ev));
    if (ev) begin
      cmp({tag, " pc"}, o.pc, it.pc);
      cmp({tag, " opcode"}, 64'(o.opcode), fld(it.instr, 6, 0));
      cmp({tag, " rd"}, 64'(o.rd), fld(it.instr, 11, 7));
      cmp({tag, " rs1"}, 64'(o.rs1), fld(it.instr, 19, 15));
      cmp({tag, " rs2"}, 64'(o.rs2), fld(it.instr, 24, 20));
      cmp({tag, " funct3"}, 64'(o.f3), fld(it.instr, 14, 12));
      cmp({tag, " funct7"}, 64'(o.f7), fld(it.instr, 31, 25));
      cmp({tag, " imm"}, o.imm, ref_imm(it.instr));
      cmp({tag, " illegal"}, 64'(o.illegal), 64'(ref_illegal(it.instr)));
    end
  endtask

  // ---------------- driver ----------------
  // One cycle: drive at negedge, check against the model, advance the model.
  task automatic step(input bit r, input bit f, input bit v, input logic [31:0] ins,
                      input logic [63:0] p, input bit ordy, output bit acc1, output bit rdy1);
    bit    er0, er1;
    item_t it, h0, h1;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; instr = ins; pc = p; out_ready = ordy;
    #1;
    it.instr = ins; it.pc = p;
    h0 = '{default: '0}; h1 = '{default: '0};
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    er0 = (q0.size() == 0) || ordy;
    er1 = (q1.size() < 2);
    if (!r && reset_seen) begin
      check_obs("d0", obs0, q0.size() > 0, er0, h0);
      check_obs("d1", obs1, q1.size() > 0, er1, h1);
    end
    acc1 = v && in_ready1 && !f && !r;
    rdy1 = in_ready1;
    if (out_valid1 && ordy && !r && !f) seen1.push_back(pc_o1);
    if (r || f) begin
      q0.delete();
      q1.delete();
    end else begin
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (v && er0) q0.push_back(it);
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (v && er1) q1.push_back(it);
    end
    if (r) reset_seen = 1;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 64'h0, 1, a, b);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
    logic        ill;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit          a, b;
    bit          rdy_hist[8];
    logic [31:0] sins[4];
    logic [63:0] spc[4];
    logic [6:0]  opc_list[13];
    int          k, cyc;
    bit          leak;

    tbl[0] = '{32'hFFF1_0093, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[1] = '{32'h0051_2423, 5'd8, 5'd2, 5'd5, 3'd2, 7'h00, 64'h0000_0000_0000_0008, 1'b0};
    tbl[2] = '{32'hFE00_0EE3, 5'd29, 5'd0, 5'd0, 3'd0, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    tbl[3] = '{32'h1234_50B7, 5'd1, 5'd8, 5'd3, 3'd5, 7'h09, 64'h0000_0000_1234_5000, 1'b0};
    tbl[4] = '{32'h8000_00B7, 5'd1, 5'd0, 5'd0, 3'd0, 7'h40, 64'hFFFF_FFFF_8000_0000, 1'b0};
    tbl[5] = '{32'hFFDF_F0EF, 5'd1, 5'd31, 5'd29, 3'd7, 7'h7F, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
`ifdef DECODE_ILLEGAL_CHECK_EN
    tbl[6] = '{32'h0000_0000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 1'b1};
`else
    tbl[6] = '{32'h0000_0000, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 64'h0, 1'b0};
`endif
    opc_list = '{7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h13, 7'h1B,
                 7'h33, 7'h3B, 7'h0F, 7'h73};

    // Reset state
    step(1, 0, 0, 32'h0, 64'h0, 0, a, b);
    step(1, 0, 1, 32'hFFFF_FFFF, 64'hFFFF, 0, a, b);
    #2;
    cmp("rst d0 out_valid", 64'(out_valid0), 64'd0);
    cmp("rst d1 out_valid", 64'(out_valid1), 64'd0);
    cmp("rst d1 in_ready", 64'(in_ready1), 64'd1);
    cmp("rst d0 pc", pc_o0, 64'd0);
    cmp("rst d1 imm", imm1, 64'd0);
    cmp("rst d1 opcode", 64'(opc1), 64'd0);
    cmp("rst d0 rd", 64'(rd0), 64'd0);

    // Table vectors, back-to-back with out_ready=1
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, tbl[i].instr, 64'h8000_1000 + 64'(4 * i), 1, a, b);
      #2;
      cmp("vec valid", 64'(out_valid0), 64'd1);
      cmp("vec pc", pc_o0, 64'h8000_1000 + 64'(4 * i));
      cmp("vec rd", 64'(rd0), 64'(tbl[i].rd));
      cmp("vec rs1", 64'(rs1_0), 64'(tbl[i].rs1));
      cmp("vec rs2", 64'(rs2_0), 64'(tbl[i].rs2));
      cmp("vec funct3", 64'(f3_0), 64'(tbl[i].f3));
      cmp("vec funct7", 64'(f7_0), 64'(tbl[i].f7));
      cmp("vec imm", imm0, tbl[i].imm);
      cmp("vec imm skid", imm1, tbl[i].imm);
      cmp("vec illegal", 64'(ill0), 64'(tbl[i].ill));
    end
    idle(3);

    // Skid stall: 4 instructions, out_ready low for the first 3 cycles
    seen1.delete();
    for (int i = 0; i < 4; i++) begin
      sins[i] = 32'h0000_0013 | (32'(i + 1) << 20);
      spc[i]  = 64'h4000 + 64'(16 * i);
    end
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      step(0, 0, 1, sins[k], spc[k], cyc >= 3, a, b);
      if (cyc < 8) rdy_hist[cyc] = b;
      if (a) k++;
      cyc++;
    end
    cmp("stall accepted all", 64'(k), 64'd4);
    cmp("stall ready c0", 64'(rdy_hist[0]), 64'd1);
    cmp("stall ready c1", 64'(rdy_hist[1]), 64'd1);
    cmp("stall ready c2 falls", 64'(rdy_hist[2]), 64'd0);
    cmp("stall ready c3 held", 64'(rdy_hist[3]), 64'd0);
    cmp("stall ready c4 rises", 64'(rdy_hist[4]), 64'd1);
    idle(6);
    cmp("stall count", 64'(seen1.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < seen1.size()) cmp("stall order", seen1[i], spc[i]);

    // Flush with output and skid full plus a simultaneous input
    seen1.delete();
    step(0, 0, 1, 32'h0010_0093, 64'hF000, 0, a, b);
    step(0, 0, 1, 32'h0020_0093, 64'hF004, 0, a, b);
    step(0, 1, 1, 32'h0030_0093, 64'hF008, 1, a, b);
    #2;
    cmp("flush d1 out_valid", 64'(out_valid1), 64'd0);
    cmp("flush d1 in_ready", 64'(in_ready1), 64'd1);
    cmp("flush d0 out_valid", 64'(out_valid0), 64'd0);
    idle(4);
    leak = 0;
    foreach (seen1[i]) if (seen1[i] >= 64'hF000 && seen1[i] <= 64'hF008) leak = 1;
    cmp("flush leak", 64'(leak), 64'd0);

    // Reset in the middle of a stall
    step(0, 0, 1, 32'h0040_0093, 64'hE000, 0, a, b);
    step(0, 0, 1, 32'h0050_0093, 64'hE004, 0, a, b);
    step(1, 0, 1, 32'h0060_0093, 64'hE008, 0, a, b);
    #2;
    cmp("midrst d1 out_valid", 64'(out_valid1), 64'd0);
    cmp("midrst d0 out_valid", 64'(out_valid0), 64'd0);
    cmp("midrst d1 in_ready", 64'(in_ready1), 64'd1);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] r;
      logic [6:0]  op;
      r  = $urandom();
      op = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : opc_list[$urandom_range(0, 12)];
      step($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0,
           {r[31:7], op}, {$urandom(), $urandom()}, $urandom_range(0, 2) != 0, a, b);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
